pio_dmem_port_arb: RTL

- Arbiter and sequencer for port B of a PIO-accessible dual-port data-memory BRAM.
- Shares the single port B between NREQ application requesters and one PIO host access, one access per clock.
- Application requesters are served round-robin; the PIO access is guaranteed service by a starvation bound.
- Returns read data to each winner and produces the clk_div-paced PIO mem_ack / PIO read data.

---
 rtl/pio_dmem_port_arb_if.sv | 37 +++
 rtl/pio_dmem_port_arb.sv | 101 ++++++++++
 2 files changed

// File: rtl/pio_dmem_port_arb_if.sv
// pio_dmem_port_arb_if: PIO host, application requester and BRAM port-B signals of the arbiter
interface pio_dmem_port_arb_if #(
  parameter int WIDTH       = 32,
  parameter int DEPTH_NBITS = 10,
  parameter int NREQ        = 2,
  parameter int PIO_NBITS   = 32
);
  logic                        clk_div;
  logic [PIO_NBITS-1:0]        reg_addr;
  logic [PIO_NBITS-1:0]        reg_din;
  logic                        reg_rd;
  logic                        reg_wr;
  logic                        reg_ms;
  logic                        mem_ack;
  logic [PIO_NBITS-1:0]        pio_rdata;
  logic [NREQ-1:0]             req_vld;
  logic [NREQ-1:0]             req_wr;
  logic [NREQ*DEPTH_NBITS-1:0] req_addr;
  logic [NREQ*WIDTH-1:0]       req_wdata;
  logic [NREQ-1:0]             req_gnt;
  logic [NREQ-1:0]             rd_vld;
  logic [WIDTH-1:0]            rd_data;
  logic                        mem_we;
  logic [DEPTH_NBITS-1:0]      mem_addr;
  logic [WIDTH-1:0]            mem_wdata;
  logic [WIDTH-1:0]            mem_dout;
  modport master (
    output clk_div, reg_addr, reg_din, reg_rd, reg_wr, reg_ms,
    output req_vld, req_wr, req_addr, req_wdata, mem_dout,
    input  mem_ack, pio_rdata, req_gnt, rd_vld, rd_data, mem_we, mem_addr, mem_wdata
  );
  modport slave (
    input  clk_div, reg_addr, reg_din, reg_rd, reg_wr, reg_ms,
    input  req_vld, req_wr, req_addr, req_wdata, mem_dout,
    output mem_ack, pio_rdata, req_gnt, rd_vld, rd_data, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/pio_dmem_port_arb.sv
// pio_dmem_port_arb: round-robin/PIO arbiter and sequencer for BRAM port B with clk_div-paced PIO ack
module pio_dmem_port_arb #(
  parameter int WIDTH       = 32,
  parameter int DEPTH_NBITS = 10,
  parameter int NREQ        = 2,
  parameter int PIO_STARVE  = 8,
  parameter int REG_WR_EN   = 1,
  parameter int PIO_NBITS   = 32
) (
  input logic clk,
  input logic rst,
  pio_dmem_port_arb_if.slave bus
);
  localparam int RW = NREQ > 1 ? $clog2(NREQ) : 1;
  localparam int SW = $clog2(PIO_STARVE + 1);
  logic pio_pend_q, pio_pend_d, pio_wr_q, pio_wr_d, pio_busy_q, pio_busy_d;
  logic ack_pend_q, ack_pend_d, mem_ack_q, mem_ack_d;
  logic [DEPTH_NBITS-1:0] pio_addr_q, pio_addr_d;
  logic [WIDTH-1:0] pio_data_q, pio_data_d;
  logic [PIO_NBITS-1:0] pio_rdata_q, pio_rdata_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [RW-1:0] rr_q, rr_d, app_idx, lo_idx, hi_idx;
  logic [NREQ-1:0] rd_vld_q, rd_vld_d, app_vld, app_oh;
  logic lo_any, hi_any, pio_req, gnt_pio, gnt_app, cap, done;
  logic unused_ok;
  assign unused_ok = &{1'b0, bus.reg_addr, bus.reg_din};
  // Lowest requester at/after the pointer wins; otherwise the lowest overall (wrap-around).
  always_comb begin
    app_vld = rst ? '0 : bus.req_vld;
    lo_idx = '0;
    hi_idx = '0;
    lo_any = 1'b0;
    hi_any = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (app_vld[i]) begin
        lo_idx = RW'(i);
        lo_any = 1'b1;
        if (i >= int'(rr_q)) begin
          hi_idx = RW'(i);
          hi_any = 1'b1;
        end
      end
    end
    app_idx = hi_any ? hi_idx : lo_idx;
  end
  // A PIO read in flight is not re-arbitrated while waiting for its data.
  assign pio_req = pio_pend_q & ~pio_busy_q & ~rst;
  assign gnt_pio = pio_req & ((starve_q >= SW'(PIO_STARVE)) | ~lo_any);
  assign gnt_app = lo_any & ~gnt_pio;
  assign app_oh  = gnt_app ? NREQ'(1) << app_idx : '0;
  assign done    = (gnt_pio & pio_wr_q) | pio_busy_q;
  assign cap     = bus.reg_ms & (bus.reg_rd | bus.reg_wr) & ~pio_pend_q;
  always_comb begin
    pio_pend_d  = done ? 1'b0 : (cap | pio_pend_q);
    pio_wr_d    = cap ? bus.reg_wr : pio_wr_q;
    pio_addr_d  = cap ? bus.reg_addr[DEPTH_NBITS+1:2] : pio_addr_q;
    pio_data_d  = cap ? bus.reg_din[WIDTH-1:0] : pio_data_q;
    pio_busy_d  = gnt_pio & ~pio_wr_q;
    starve_d    = gnt_pio ? '0 : (pio_req & (starve_q < SW'(PIO_STARVE))) ? starve_q + SW'(1) : starve_q;
    rr_d        = gnt_app ? ((app_idx == RW'(NREQ - 1)) ? '0 : app_idx + RW'(1)) : rr_q;
    rd_vld_d    = app_oh & ~bus.req_wr;
    pio_rdata_d = pio_busy_q ? PIO_NBITS'(bus.mem_dout) : pio_rdata_q;
    mem_ack_d   = bus.clk_div ? (ack_pend_q | done) : mem_ack_q;
    ack_pend_d  = bus.clk_div ? 1'b0 : (ack_pend_q | done);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pio_pend_q  <= 1'b0;
      pio_wr_q    <= 1'b0;
      pio_busy_q  <= 1'b0;
      pio_addr_q  <= '0;
      pio_data_q  <= '0;
      pio_rdata_q <= '0;
      starve_q    <= '0;
      rr_q        <= '0;
      rd_vld_q    <= '0;
      ack_pend_q  <= 1'b0;
      mem_ack_q   <= 1'b0;
    end else begin
      pio_pend_q  <= pio_pend_d;
      pio_wr_q    <= pio_wr_d;
      pio_busy_q  <= pio_busy_d;
      pio_addr_q  <= pio_addr_d;
      pio_data_q  <= pio_data_d;
      pio_rdata_q <= pio_rdata_d;
      starve_q    <= starve_d;
      rr_q        <= rr_d;
      rd_vld_q    <= rd_vld_d;
      ack_pend_q  <= ack_pend_d;
      mem_ack_q   <= mem_ack_d;
    end
  end
  assign bus.req_gnt   = app_oh;
  assign bus.mem_we    = gnt_pio ? (pio_wr_q & (REG_WR_EN != 0)) : (gnt_app & bus.req_wr[app_idx]);
  assign bus.mem_addr  = gnt_pio ? pio_addr_q : gnt_app ? bus.req_addr[app_idx*DEPTH_NBITS +: DEPTH_NBITS] : '0;
  assign bus.mem_wdata = gnt_pio ? pio_data_q : gnt_app ? bus.req_wdata[app_idx*WIDTH +: WIDTH] : '0;
  assign bus.mem_ack   = mem_ack_q;
  assign bus.pio_rdata = pio_rdata_q;
  assign bus.rd_vld    = rd_vld_q;
  assign bus.rd_data   = |rd_vld_q ? bus.mem_dout : '0;
endmodule
